if_fetch_queue: RTL and testbench

- Instruction-fetch stage directly upstream of the decode/immediate-extension stage.
- Issues sequential PCs to a synchronous instruction ROM with fixed 1-cycle read latency.
- Buffers returned words in a small FIFO.
- Presents {pc, inst} to ID with a valid/ready handshake; handles branch/jump redirects from EX.

---
 rtl/if_fetch_queue.sv | 107 ++++++++++
 tb/tb_if_fetch_queue.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: sequential PC issue to a 1-cycle ROM, small {pc, inst} queue toward ID.
// Optional FETCH_PERF_CNT_EN adds bubble and flush counters.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic        irom_req,
  output logic [31:0] irom_addr,
  input  logic [31:0] irom_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic [31:0] id_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;

  // Slots already promised: queued entries plus the word arriving from the ROM.
  assign occupancy = {1'b0, count} + (CW + 1)'(inflight);

  assign id_valid  = ~cpu_rst & (count != '0);
  assign id_pc     = id_valid ? q_pc[rd_ptr]   : 32'h0000_0000;
  assign id_inst   = id_valid ? q_inst[rd_ptr] : NOP_INST;

  assign pop       = id_valid & id_ready & ~redirect_valid;
  assign push      = ~cpu_rst & inflight & ~redirect_valid;
  assign issue     = ~cpu_rst & ~redirect_valid &
                     ((occupancy < (CW + 1)'(DEPTH)) | pop);

  assign irom_req  = issue;
  assign irom_addr = pc_q;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0000_0000;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_valid) begin
      // Flush everything, including the ROM word returning this cycle.
      pc_q     <= redirect_pc;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_q        <= pc_q + 32'd4;
        inflight_pc <= pc_q;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= inflight_pc;
      q_inst[wr_ptr] <= irom_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      perf_bubble_cnt <= 32'd0;
      perf_flush_cnt  <= 32'd0;
    end else begin
      if (!redirect_valid && !id_valid) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (redirect_valid)               perf_flush_cnt  <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: streaming, stall/backpressure, redirects, PC wrap and mid-stream reset.
module tb_if_fetch_queue;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic [31:0] irom_rdata = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] ROM_XOR = 32'hA5A5_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  if_fetch_queue #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2),
    .NOP_INST(NOP)
  ) dut (
    .cpu_clk       (cpu_clk),
    .cpu_rst       (cpu_rst),
    .irom_req      (irom_req),
    .irom_addr     (irom_addr),
    .irom_rdata    (irom_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_inst       (id_inst)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Instruction ROM with one-cycle read latency; contents derived from the address.
  always @(posedge cpu_clk) irom_rdata <= irom_addr ^ ROM_XOR;

  task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] rpc,
                               input logic rdy);
    @(negedge cpu_clk);
    cpu_rst        = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expectIssue(input string tag, input logic [31:0] addr);
    checkOutput({tag, ".req"}, {31'b0, irom_req}, 32'd1);
    checkOutput({tag, ".addr"}, irom_addr, addr);
  endtask

  task automatic expectNoIssue(input string tag);
    checkOutput({tag, ".req"}, {31'b0, irom_req}, 32'd0);
  endtask

  task automatic expectEmpty(input string tag);
    checkOutput({tag, ".valid"}, {31'b0, id_valid}, 32'd0);
    checkOutput({tag, ".pc"}, id_pc, 32'h0);
    checkOutput({tag, ".inst"}, id_inst, NOP);
  endtask

  task automatic expectHead(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    checkOutput({tag, ".valid"}, {31'b0, id_valid}, 32'd1);
    checkOutput({tag, ".pc"}, id_pc, pc);
    checkOutput({tag, ".inst"}, id_inst, inst);
  endtask

  initial begin
    cpu_rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;

    // Reset state
    applyStimulus(1, 0, 0, 1); expectNoIssue("rst0"); expectEmpty("rst0");
    applyStimulus(1, 0, 0, 1); expectNoIssue("rst1"); expectEmpty("rst1");

    // Streaming with id_ready held high
    applyStimulus(0, 0, 0, 1); expectIssue("str0", 32'h0);  expectEmpty("str0");
    applyStimulus(0, 0, 0, 1); expectIssue("str1", 32'h4);  expectEmpty("str1");
    applyStimulus(0, 0, 0, 1); expectIssue("str2", 32'h8);  expectHead("str2", 32'h0, 32'hA5A5_0000);
    applyStimulus(0, 0, 0, 1); expectIssue("str3", 32'hC);  expectHead("str3", 32'h4, 32'hA5A5_0004);
    applyStimulus(0, 0, 0, 1); expectIssue("str4", 32'h10); expectHead("str4", 32'h8, 32'hA5A5_0008);

    // Backpressure: id_ready low for six cycles from the first fetch
    applyStimulus(1, 0, 0, 1); expectNoIssue("rst2"); expectEmpty("rst2");
    applyStimulus(0, 0, 0, 0); expectIssue("stl0", 32'h0); expectEmpty("stl0");
    applyStimulus(0, 0, 0, 0); expectIssue("stl1", 32'h4); expectEmpty("stl1");
    applyStimulus(0, 0, 0, 0); expectNoIssue("stl2"); expectHead("stl2", 32'h0, 32'hA5A5_0000);
    applyStimulus(0, 0, 0, 0); expectNoIssue("stl3"); expectHead("stl3", 32'h0, 32'hA5A5_0000);
    applyStimulus(0, 0, 0, 0); expectNoIssue("stl4"); expectHead("stl4", 32'h0, 32'hA5A5_0000);
    applyStimulus(0, 0, 0, 0); expectNoIssue("stl5"); expectHead("stl5", 32'h0, 32'hA5A5_0000);
    applyStimulus(0, 0, 0, 1); expectIssue("rsm0", 32'h8); expectHead("rsm0", 32'h0, 32'hA5A5_0000);
    applyStimulus(0, 0, 0, 1); expectIssue("rsm1", 32'hC); expectHead("rsm1", 32'h4, 32'hA5A5_0004);

    // Redirect to 0x200 with a queued entry and a response in flight
    applyStimulus(0, 1, 32'h0000_0200, 1); expectNoIssue("rdA0");
    applyStimulus(0, 0, 0, 1); expectIssue("rdA1", 32'h200); expectEmpty("rdA1");
    applyStimulus(0, 0, 0, 1); expectIssue("rdA2", 32'h204); expectEmpty("rdA2");
    applyStimulus(0, 0, 0, 1); expectIssue("rdA3", 32'h208); expectHead("rdA3", 32'h200, 32'hA5A5_0200);
    applyStimulus(0, 0, 0, 1); expectIssue("rdA4", 32'h20C); expectHead("rdA4", 32'h204, 32'hA5A5_0204);

    // Redirect near the top of the address space; PC wraps to zero
    applyStimulus(0, 1, 32'hFFFF_FFF8, 1); expectNoIssue("rdB0");
    applyStimulus(0, 0, 0, 1); expectIssue("rdB1", 32'hFFFF_FFF8); expectEmpty("rdB1");
    applyStimulus(0, 0, 0, 1); expectIssue("rdB2", 32'hFFFF_FFFC); expectEmpty("rdB2");
    applyStimulus(0, 0, 0, 1); expectIssue("rdB3", 32'h0);
    expectHead("rdB3", 32'hFFFF_FFF8, 32'h5A5A_FFF8);
    applyStimulus(0, 0, 0, 1); expectIssue("rdB4", 32'h4);
    expectHead("rdB4", 32'hFFFF_FFFC, 32'h5A5A_FFFC);
    applyStimulus(0, 0, 0, 1); expectIssue("rdB5", 32'h8);
    expectHead("rdB5", 32'h0, 32'hA5A5_0000);

    // Fill the queue, then reset mid-stream
    applyStimulus(0, 0, 0, 0); expectNoIssue("fil0"); expectHead("fil0", 32'h4, 32'hA5A5_0004);
    applyStimulus(0, 0, 0, 0); expectNoIssue("fil1"); expectHead("fil1", 32'h4, 32'hA5A5_0004);
    applyStimulus(1, 0, 0, 0); expectNoIssue("mrst0"); expectEmpty("mrst0");
    applyStimulus(1, 0, 0, 1); expectNoIssue("mrst1"); expectEmpty("mrst1");
    applyStimulus(0, 0, 0, 1); expectIssue("rel0", 32'h0); expectEmpty("rel0");
    applyStimulus(0, 0, 0, 1); expectIssue("rel1", 32'h4); expectEmpty("rel1");
    applyStimulus(0, 0, 0, 1); expectIssue("rel2", 32'h8); expectHead("rel2", 32'h0, 32'hA5A5_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
